// File: rtl/router_fsm_if.sv
// Handshake bundle between the packet router datapath and its control FSM.
// ROUTER_FSM_DROP_CNT_EN adds the drop_cnt status output.
interface router_fsm_if;
  logic       pkt_valid;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       fifo_full;
  logic [1:0] data_in;
  logic       fifo_empty_0;
  logic       fifo_empty_1;
  logic       fifo_empty_2;
  logic       soft_reset_0;
  logic       soft_reset_1;
  logic       soft_reset_2;
  logic       detect_add;
  logic       lfd_state;
  logic       ld_state;
  logic       laf_state;
  logic       full_state;
  logic       write_enb_reg;
  logic       rst_int_reg;
  logic       busy;
`ifdef ROUTER_FSM_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  modport master (
    output pkt_valid, parity_done, low_pkt_valid, fifo_full, data_in,
    output fifo_empty_0, fifo_empty_1, fifo_empty_2,
    output soft_reset_0, soft_reset_1, soft_reset_2,
`ifdef ROUTER_FSM_DROP_CNT_EN
    input  drop_cnt,
`endif
    input  detect_add, lfd_state, ld_state, laf_state, full_state,
    input  write_enb_reg, rst_int_reg, busy
  );

  modport slave (
    input  pkt_valid, parity_done, low_pkt_valid, fifo_full, data_in,
    input  fifo_empty_0, fifo_empty_1, fifo_empty_2,
    input  soft_reset_0, soft_reset_1, soft_reset_2,
`ifdef ROUTER_FSM_DROP_CNT_EN
    output drop_cnt,
`endif
    output detect_add, lfd_state, ld_state, laf_state, full_state,
    output write_enb_reg, rst_int_reg, busy
  );
endinterface

// File: rtl/router_fsm.sv
// Packet router control FSM: header decode, payload load, full handling, parity.
// ROUTER_FSM_DROP_CNT_EN adds a saturating count of soft-reset aborts.
//
// state | meaning
// DA    | decode header address, wait for a valid packet
// LFD   | write header byte
// LD    | write payload bytes
// LP    | write parity byte
// FFS   | addressed FIFO full, stall
// LAF   | resume after full
// WTE   | addressed FIFO not yet empty, wait
// CPE   | check parity, pulse internal reset
module router_fsm (
  input  logic       clock,
  input  logic       reset,
  router_fsm_if.slave rif
);

  typedef enum logic [2:0] {
    DA  = 3'd0,
    LFD = 3'd1,
    LD  = 3'd2,
    LP  = 3'd3,
    FFS = 3'd4,
    LAF = 3'd5,
    WTE = 3'd6,
    CPE = 3'd7
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] addr_q;
  logic       addr_load;
  logic       empty_in, empty_addr, soft_hit;
  logic [7:0] out_vec;

  // Empty flag selected by the incoming header, and empty/soft reset by the latched address.
  always_comb begin
    empty_in   = 1'b0;
    empty_addr = 1'b0;
    soft_hit   = 1'b0;
    case (rif.data_in)
      2'd0:    empty_in = rif.fifo_empty_0;
      2'd1:    empty_in = rif.fifo_empty_1;
      2'd2:    empty_in = rif.fifo_empty_2;
      default: empty_in = 1'b0;
    endcase
    case (addr_q)
      2'd0:    begin empty_addr = rif.fifo_empty_0; soft_hit = rif.soft_reset_0; end
      2'd1:    begin empty_addr = rif.fifo_empty_1; soft_hit = rif.soft_reset_1; end
      2'd2:    begin empty_addr = rif.fifo_empty_2; soft_hit = rif.soft_reset_2; end
      default: begin empty_addr = 1'b0;             soft_hit = 1'b0;             end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    addr_load = 1'b0;
    case (state_q)
      DA: begin
        if (rif.pkt_valid && (rif.data_in != 2'd3)) begin
          addr_load = 1'b1;
          state_d   = empty_in ? LFD : WTE;
        end
      end
      LFD: state_d = LD;
      LD: begin
        if (rif.fifo_full)       state_d = FFS;
        else if (!rif.pkt_valid) state_d = LP;
      end
      FFS: if (!rif.fifo_full) state_d = LAF;
      LAF: begin
        if (rif.parity_done)        state_d = DA;
        else if (rif.low_pkt_valid) state_d = LP;
        else                        state_d = LD;
      end
      LP:  state_d = CPE;
      CPE: state_d = rif.fifo_full ? FFS : DA;
      WTE: if (empty_addr) state_d = LFD;
      default: state_d = DA;
    endcase
    // An abort from the addressed FIFO wins over every other transition.
    if ((state_q != DA) && soft_hit) state_d = DA;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= DA;
      addr_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      if (addr_load) addr_q <= rif.data_in;
    end
  end

  // out_vec = {detect_add, lfd, ld, laf, full, write_enb, rst_int, busy}
  always_comb begin
    out_vec = 8'b0000_0000;
    case (state_q)
      DA:      out_vec = 8'b1000_0000;
      LFD:     out_vec = 8'b0100_0101;
      LD:      out_vec = 8'b0010_0100;
      LP:      out_vec = 8'b0000_0101;
      FFS:     out_vec = 8'b0000_1001;
      LAF:     out_vec = 8'b0001_0101;
      WTE:     out_vec = 8'b0000_0001;
      CPE:     out_vec = 8'b0000_0011;
      default: out_vec = 8'b0000_0000;
    endcase
  end

  assign rif.detect_add    = out_vec[7];
  assign rif.lfd_state     = out_vec[6];
  assign rif.ld_state      = out_vec[5];
  assign rif.laf_state     = out_vec[4];
  assign rif.full_state    = out_vec[3];
  assign rif.write_enb_reg = out_vec[2];
  assign rif.rst_int_reg   = out_vec[1];
  assign rif.busy          = out_vec[0];

`ifdef ROUTER_FSM_DROP_CNT_EN
  logic [7:0] drop_cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      drop_cnt_q <= 8'd0;
    end else if ((state_q != DA) && soft_hit && (drop_cnt_q != 8'hff)) begin
      drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign rif.drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_router_fsm.sv
// Directed bench for router_fsm; states are identified by their unique output decode.
module tb_router_fsm;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  router_fsm_if rif();

  router_fsm dut (
    .clock (clock),
    .reset (reset),
    .rif   (rif.slave)
  );

  // {detect_add, lfd, ld, laf, full, write_enb, rst_int, busy}
  localparam logic [7:0] O_DA  = 8'b1000_0000;
  localparam logic [7:0] O_LFD = 8'b0100_0101;
  localparam logic [7:0] O_LD  = 8'b0010_0100;
  localparam logic [7:0] O_LP  = 8'b0000_0101;
  localparam logic [7:0] O_FFS = 8'b0000_1001;
  localparam logic [7:0] O_LAF = 8'b0001_0101;
  localparam logic [7:0] O_WTE = 8'b0000_0001;
  localparam logic [7:0] O_CPE = 8'b0000_0011;

  int n_err = 0;
  int n_chk = 0;

  logic [7:0] outv;
  assign outv = {rif.detect_add, rif.lfd_state, rif.ld_state, rif.laf_state,
                 rif.full_state, rif.write_enb_reg, rif.rst_int_reg, rif.busy};

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] exp);
    n_chk++;
    assert (outv === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%b expected=%b", tag, outv, exp);
    end
  endtask

  task automatic chk_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [7:0] exp);
    tick();
    chk(tag, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    rif.pkt_valid = 0; rif.parity_done = 0; rif.low_pkt_valid = 0; rif.fifo_full = 0;
    rif.data_in = 2'd0;
    rif.fifo_empty_0 = 0; rif.fifo_empty_1 = 0; rif.fifo_empty_2 = 0;
    rif.soft_reset_0 = 0; rif.soft_reset_1 = 0; rif.soft_reset_2 = 0;

    // reset asserted
    #2;
    chk("reset_async", O_DA);
    tick();
    chk("reset_held", O_DA);
`ifdef ROUTER_FSM_DROP_CNT_EN
    chk_val("drop_reset", rif.drop_cnt, 8'd0);
`endif
    reset = 1'b0;
    step("idle_da", O_DA);

    // normal packet to FIFO 1
    rif.pkt_valid = 1; rif.data_in = 2'd1; rif.fifo_empty_1 = 1;
    step("pkt_lfd", O_LFD);
    step("pkt_ld1", O_LD);
    step("pkt_ld2", O_LD);
    step("pkt_ld3", O_LD);
    step("pkt_ld4", O_LD);
    rif.pkt_valid = 0;
    step("pkt_lp", O_LP);
    step("pkt_cpe", O_CPE);
    step("pkt_da", O_DA);

    // full during payload, resume via low_pkt_valid
    rif.pkt_valid = 1;
    step("full_lfd", O_LFD);
    step("full_ld", O_LD);
    rif.fifo_full = 1;
    step("full_ffs1", O_FFS);
    step("full_ffs2", O_FFS);
    step("full_ffs3", O_FFS);
    rif.fifo_full = 0; rif.low_pkt_valid = 1;
    step("full_laf", O_LAF);
    step("full_lp", O_LP);
    rif.pkt_valid = 0; rif.low_pkt_valid = 0;
    step("full_cpe", O_CPE);
    step("full_da", O_DA);

    // FIFO 2 busy: wait until empty; data_in changes must not matter
    rif.pkt_valid = 1; rif.data_in = 2'd2; rif.fifo_empty_2 = 0;
    step("wte_1", O_WTE);
    rif.pkt_valid = 0; rif.data_in = 2'd1;
    for (int i = 2; i <= 5; i++) step($sformatf("wte_%0d", i), O_WTE);
    rif.fifo_empty_2 = 1;
    step("wte_lfd", O_LFD);
    step("wte_ld", O_LD);
    step("wte_lp", O_LP);
    step("wte_cpe", O_CPE);
    step("wte_da", O_DA);

    // invalid address 3 is ignored, addr keeps 2
    rif.pkt_valid = 1; rif.data_in = 2'd3;
    rif.fifo_empty_0 = 1; rif.fifo_empty_1 = 1; rif.fifo_empty_2 = 1;
    for (int i = 0; i < 10; i++) step($sformatf("inv_da_%0d", i), O_DA);
    chk_val("inv_addr", {6'd0, dut.addr_q}, 8'd2);

    // soft reset: only the addressed FIFO aborts
    rif.data_in = 2'd0;
    step("sr_lfd", O_LFD);
    step("sr_ld", O_LD);
    rif.soft_reset_1 = 1; rif.soft_reset_2 = 1;
    step("sr_other_ld", O_LD);
`ifdef ROUTER_FSM_DROP_CNT_EN
    chk_val("drop_before", rif.drop_cnt, 8'd0);
`endif
    rif.soft_reset_1 = 0; rif.soft_reset_2 = 0; rif.soft_reset_0 = 1; rif.pkt_valid = 0;
    step("sr_abort_da", O_DA);
`ifdef ROUTER_FSM_DROP_CNT_EN
    chk_val("drop_after", rif.drop_cnt, 8'd1);
`endif
    step("sr_stay_da", O_DA);
    rif.soft_reset_0 = 0;

    // async reset mid-packet
    rif.pkt_valid = 1; rif.data_in = 2'd1;
    step("rst_lfd", O_LFD);
    step("rst_ld", O_LD);
    reset = 1'b1;
    #1;
    chk("rst_mid_da", O_DA);
`ifdef ROUTER_FSM_DROP_CNT_EN
    chk_val("drop_rst", rif.drop_cnt, 8'd0);
`endif
    tick();
    reset = 1'b0;
    step("rst_rel_lfd", O_LFD);
    step("rst_rel_ld", O_LD);

    // CPE->FFS, LAF->LD, full priority in LD, LAF parity_done->DA
    rif.pkt_valid = 0;
    step("b_lp", O_LP);
    step("b_cpe", O_CPE);
    rif.fifo_full = 1;
    step("b_cpe_ffs", O_FFS);
    rif.fifo_full = 0;
    step("b_laf", O_LAF);
    step("b_laf_ld", O_LD);
    rif.fifo_full = 1;
    step("b_full_prio", O_FFS);
    rif.fifo_full = 0;
    step("b_laf2", O_LAF);
    rif.parity_done = 1; rif.low_pkt_valid = 1;
    step("b_parity_da", O_DA);
    rif.parity_done = 0; rif.low_pkt_valid = 0;
    step("b_idle", O_DA);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/router_fsm.md
ROUTER_FSM -- requirements
Module: router_fsm

Interface
REQ-001 SHALL have port clock, input, 1, single rising-edge clock for all state.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have ports pkt_valid (in, 1), parity_done (in, 1), low_pkt_valid (in, 1), fifo_full (in, 1): packet-valid from source, parity-byte-stored, packet-ended-while-full, and full of the addressed FIFO.
REQ-004 SHALL have ports data_in (in, 2), fifo_empty_0/1/2 (in, 1 each), soft_reset_0/1/2 (in, 1 each): header address bits, per-FIFO empty flags, per-FIFO soft resets.
REQ-005 SHALL have outputs detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg, rst_int_reg, busy (1 each): Moore state decodes.

Function
REQ-006 SHALL implement 8 states: DECODE_ADDRESS (DA), LOAD_FIRST_DATA (LFD), LOAD_DATA (LD), LOAD_PARITY (LP), FIFO_FULL_STATE (FFS), LOAD_AFTER_FULL (LAF), WAIT_TILL_EMPTY (WTE), CHECK_PARITY_ERROR (CPE).
REQ-007 SHALL decode outputs combinationally from the state register only, valid in the first cycle of each state, so latency is 0 cycles from state entry.
REQ-008 SHALL drive in DA: detect_add=1. In LFD: lfd_state=1, busy=1, write_enb_reg=1. In LD: ld_state=1, write_enb_reg=1, busy=0.
REQ-009 SHALL drive in FFS: full_state=1, busy=1. In LAF: laf_state=1, busy=1, write_enb_reg=1. In LP: busy=1, write_enb_reg=1. In CPE: rst_int_reg=1, busy=1. In WTE: busy=1. All unlisted outputs 0.
REQ-010 SHALL transition from DA: pkt_valid=1, data_in!=3, fifo_empty_[data_in]=1 -> LFD; pkt_valid=1, data_in!=3, fifo_empty_[data_in]=0 -> WTE; otherwise stay.
REQ-011 SHALL latch data_in into a 2-bit addr register on every DA exit; addr holds until next DA exit.
REQ-012 SHALL transition LFD -> LD unconditionally.
REQ-013 SHALL transition from LD: fifo_full=1 -> FFS; else pkt_valid=0 -> LP; else stay (fifo_full takes priority).
REQ-014 SHALL transition from FFS: fifo_full=0 -> LAF; else stay.
REQ-015 SHALL transition from LAF: parity_done=1 -> DA; else low_pkt_valid=1 -> LP; else -> LD (parity_done priority).
REQ-016 SHALL transition LP -> CPE unconditionally.
REQ-017 SHALL transition from CPE: fifo_full=1 -> FFS; else -> DA.
REQ-018 SHALL transition from WTE: fifo_empty_[addr]=1 -> LFD; else stay.
REQ-019 SHALL, in any state other than DA, go to DA on the next edge when soft_reset_[addr]=1, overriding all other transitions; soft resets of non-addressed FIFOs SHALL be ignored.
REQ-020 SHALL treat data_in=3 as invalid: no DA exit, no addr update.
REQ-021 SHALL, on any unreachable state encoding, go to DA on the next edge.

Reset
REQ-022 SHALL on reset=1 asynchronously force state=DA and addr=0, giving detect_add=1 and all other outputs 0 while reset is asserted.
REQ-023 SHALL abandon any in-progress packet on reset mid-operation; first edge after release evaluates DA transitions.

Configuration
REQ-024 SHALL, with ROUTER_FSM_DROP_CNT_EN defined, add output drop_cnt (8 bits, reset 0) incrementing by 1 on each soft-reset abort of REQ-019, saturating at 255.
REQ-025 SHALL, without ROUTER_FSM_DROP_CNT_EN, omit drop_cnt port and counter logic entirely; all other behaviour identical.

Verification
REQ-026 SHALL cover: reset=1 -> state DA, detect_add=1, busy=0, write_enb_reg=0.
REQ-027 SHALL cover: pkt_valid=1, data_in=1, fifo_empty_1=1, 4 payload cycles, pkt_valid=0 -> DA,LFD,LD x4,LP,CPE,DA; write_enb_reg=1 from LFD through LP.
REQ-028 SHALL cover: fifo_full=1 in LD for 3 cycles then 0, parity_done=0, low_pkt_valid=1 -> LD,FFS x3,LAF,LP,CPE,DA; write_enb_reg=0 in FFS.
REQ-029 SHALL cover: data_in=2, fifo_empty_2=0 for 5 cycles then 1 -> WTE x5 with busy=1, then LFD.
REQ-030 SHALL cover: addr=0 in LD, soft_reset_1=1 -> stays LD; soft_reset_0=1 -> DA next edge, drop_cnt 0->1 when ROUTER_FSM_DROP_CNT_EN defined.
REQ-031 SHALL cover: pkt_valid=1, data_in=3 for 10 cycles -> remains DA, addr unchanged.
